// File: rtl/universal_shift_reg_if.sv
// Universal shift register bus: mode/data/serial inputs and register outputs.
// Ports: s, d, sir, sil (to register); q, sor, sol, cnt, done (from register).
interface universal_shift_reg_if #(
    parameter int WIDTH = 4,
    parameter int CNTW  = $clog2(WIDTH)
);
    logic [1:0]       s;
    logic [WIDTH-1:0] d;
    logic             sir;
    logic             sil;
    logic [WIDTH-1:0] q;
    logic             sor;
    logic             sol;
    logic [CNTW-1:0]  cnt;
    logic             done;

    modport master (
        output s, d, sir, sil,
        input  q, sor, sol, cnt, done
    );

    modport slave (
        input  s, d, sir, sil,
        output q, sor, sol, cnt, done
    );
endinterface

// File: rtl/universal_shift_reg.sv
// WIDTH-bit universal shift register: hold / shift right / shift left / load,
// updated on the falling edge of c, with a shift counter and word-done pulse.
// Ports: c (clock, falling edge), re_ (async active-low reset),
//        bus.slave: s mode, d load data, sir/sil serial in,
//                   q contents, sor/sol serial out, cnt shifts, done pulse.
module universal_shift_reg #(
    parameter int WIDTH = 4,
    parameter int CNTW  = $clog2(WIDTH)
) (
    input logic                 c,
    input logic                 re_,
    universal_shift_reg_if.slave bus
);
    localparam logic [CNTW-1:0] CNT_LAST = CNTW'(WIDTH - 1);

    logic [WIDTH-1:0] q_q, q_d;
    logic [CNTW-1:0]  cnt_q, cnt_d;
    logic             done_q, done_d;
    logic             shift;

    always_comb begin
        q_d    = q_q;
        cnt_d  = cnt_q;
        done_d = 1'b0;
        shift  = 1'b0;
        unique case (bus.s)
            2'b00: ;
            2'b01: begin
                q_d   = {bus.sir, q_q[WIDTH-1:1]};
                shift = 1'b1;
            end
            2'b10: begin
                q_d   = {q_q[WIDTH-2:0], bus.sil};
                shift = 1'b1;
            end
            2'b11: begin
                q_d   = bus.d;
                cnt_d = '0;
            end
            default: ;
        endcase
        // Both directions advance the same word counter; wrap and
        // done happen on the same edge so back-to-back words have no gap.
        if (shift) begin
            if (cnt_q == CNT_LAST) begin
                cnt_d  = '0;
                done_d = 1'b1;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(negedge c or negedge re_) begin
        if (!re_) begin
            q_q    <= '0;
            cnt_q  <= '0;
            done_q <= 1'b0;
        end else begin
            q_q    <= q_d;
            cnt_q  <= cnt_d;
            done_q <= done_d;
        end
    end

    assign bus.q    = q_q;
    assign bus.sor  = q_q[0];
    assign bus.sol  = q_q[WIDTH-1];
    assign bus.cnt  = cnt_q;
    assign bus.done = done_q;
endmodule

// File: tb/tb_universal_shift_reg.sv
// Scoreboard bench for universal_shift_reg (WIDTH=4): inputs change on the
// rising edge of c, the DUT updates on the falling edge, outputs are checked on the next rising edge.
module tb_universal_shift_reg;
    localparam logic [1:0] HOLD = 2'b00;
    localparam logic [1:0] SR   = 2'b01;
    localparam logic [1:0] SL   = 2'b10;
    localparam logic [1:0] LD   = 2'b11;

    typedef struct {
        logic [3:0] q;
        logic [1:0] cnt;
        logic       done;
    } exp_t;

    logic c;
    logic re_;
    universal_shift_reg_if #(.WIDTH(4)) bus ();

    universal_shift_reg #(.WIDTH(4)) dut (
        .c   (c),
        .re_ (re_),
        .bus (bus)
    );

    initial c = 1'b1;
    always #5 c = ~c;

    int n_chk = 0;
    int n_err = 0;
    exp_t sbq[$];

    logic [3:0] mq;
    int         nshift;
    logic       mdone;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        mq     = 4'b0000;
        nshift = 0;
        mdone  = 1'b0;
    endtask

    // Called at a rising edge: drive, predict, then compare one edge later.
    task automatic op(input logic [1:0] s_i, input logic [3:0] d_i,
                      input logic sr, input logic sl);
        exp_t e;
        bus.s   = s_i;
        bus.d   = d_i;
        bus.sir = sr;
        bus.sil = sl;
        mdone   = 1'b0;
        case (s_i)
            SR: begin
                mq = {sr, mq[3:1]};
                nshift++;
                mdone = (nshift % 4 == 0);
            end
            SL: begin
                mq = {mq[2:0], sl};
                nshift++;
                mdone = (nshift % 4 == 0);
            end
            LD: begin
                mq     = d_i;
                nshift = 0;
            end
            default: ;
        endcase
        e.q    = mq;
        e.cnt  = 2'(nshift % 4);
        e.done = mdone;
        sbq.push_back(e);
        @(posedge c);
        if (sbq.size() == 0) begin
            chk("sb_empty", 1, 0);
        end else begin
            e = sbq.pop_front();
            chk("q", bus.q, e.q);
            chk("cnt", bus.cnt, e.cnt);
            chk("done", bus.done, e.done);
            chk("sor", bus.sor, e.q[0]);
            chk("sol", bus.sol, e.q[3]);
        end
    endtask

    // Async reset pulse between edges, with no clock edge involved.
    task automatic rst_pulse();
        bus.s = HOLD;
        #2 re_ = 1'b0;
        #1;
        chk("rst_q", bus.q, 0);
        chk("rst_cnt", bus.cnt, 0);
        chk("rst_done", bus.done, 0);
        #1 re_ = 1'b1;
        model_reset();
        @(posedge c);
        chk("rst_q_after", bus.q, 0);
    endtask

    logic [3:0] sor_exp;
    logic [1:0] cseq;

    initial begin
        re_     = 1'b0;
        bus.s   = HOLD;
        bus.d   = 4'b0000;
        bus.sir = 1'b0;
        bus.sil = 1'b0;
        model_reset();
        #1;
        chk("init_q", bus.q, 0);
        chk("init_cnt", bus.cnt, 0);
        chk("init_done", bus.done, 0);
        @(posedge c);
        re_ = 1'b1;

        // 1: async reset with clock static
        op(LD, 4'b1110, 0, 0);
        chk("t1_pre", bus.q, 4'b1110);
        rst_pulse();

        // 2: load 1011, shift right x4
        op(LD, 4'b1011, 0, 0);
        sor_exp = 4'b1011;
        for (int i = 0; i < 4; i++) begin
            chk("t2_sor", bus.sor, sor_exp[i]);
            chk("t2_nodone", bus.done, 0);
            op(SR, 4'b0000, 0, 0);
        end
        chk("t2_q", bus.q, 4'b0000);
        chk("t2_cnt", bus.cnt, 0);
        chk("t2_done", bus.done, 1);
        op(HOLD, 4'b0000, 0, 0);
        chk("t2_done_off", bus.done, 0);

        // 3: load 0001, shift left x2 with sil=1, hold x3
        op(LD, 4'b0001, 0, 0);
        op(SL, 4'b0000, 0, 1);
        op(SL, 4'b0000, 0, 1);
        chk("t3_q", bus.q, 4'b0111);
        chk("t3_cnt", bus.cnt, 2);
        chk("t3_done", bus.done, 0);
        for (int i = 0; i < 3; i++) op(HOLD, 4'b1111, 1, 1);
        chk("t3_hold_q", bus.q, 4'b0111);
        chk("t3_hold_cnt", bus.cnt, 2);

        // 4: three shifts then load aborts the word
        for (int i = 0; i < 3; i++) op(SR, 4'b0000, 1, 0);
        op(LD, 4'b1100, 0, 0);
        chk("t4_q", bus.q, 4'b1100);
        chk("t4_cnt", bus.cnt, 0);
        for (int i = 0; i < 3; i++) begin
            op(SR, 4'b0000, 0, 0);
            chk("t4_nodone", bus.done, 0);
        end
        op(SL, 4'b0000, 0, 1);
        chk("t4_done", bus.done, 1);

        // 5: continuous shift left for 8 edges
        op(LD, 4'b0110, 0, 0);
        for (int i = 1; i <= 8; i++) begin
            op(SL, 4'b0000, 0, 1'(i));
            cseq = 2'(i);
            chk("t5_cnt", bus.cnt, cseq);
            chk("t5_done", bus.done, (i == 4 || i == 8) ? 1 : 0);
        end

        // 6: reset lands during the 2nd shift of a word
        op(LD, 4'b1010, 0, 0);
        op(SR, 4'b0000, 1, 0);
        chk("t6_cnt1", bus.cnt, 1);
        bus.s = SR;
        #2 re_ = 1'b0;
        #1;
        chk("t6_q", bus.q, 0);
        chk("t6_cnt", bus.cnt, 0);
        #4;
        chk("t6_q_held", bus.q, 0);
        @(posedge c);
        bus.s = HOLD;
        re_   = 1'b1;
        model_reset();
        for (int i = 1; i <= 4; i++) begin
            op(SR, 4'b0000, 1, 0);
            chk("t6_done", bus.done, (i == 4) ? 1 : 0);
        end

        // mixed random traffic against the model
        for (int i = 0; i < 40; i++)
            op(2'($urandom_range(0, 3)), 4'($urandom),
               1'($urandom), 1'($urandom));

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout got=0 exp=1");
        $fatal(1);
    end
endmodule
